// File: rtl/task_tick_sched.sv
// Periodic task scheduler: 1 ms tick prescaler, per-task period countdowns,
// and a round-robin single-slot grant with start/done handshake and timeout.
module task_tick_sched #(
   parameter int NTASK     = 4,
   parameter int TICK_DIV  = 50000,
   parameter int PER_W     = 16,
   parameter int TMO_TICKS = 100
) (
   input  logic                   clk50M,
   input  logic                   rst,
   input  logic [NTASK-1:0]       en,
   input  logic [NTASK*PER_W-1:0] period,
   input  logic                   done,
   input  logic                   flag_clr,
   output logic                   tick,
   output logic [NTASK-1:0]       grant,
   output logic                   start,
   output logic                   busy,
   output logic [NTASK-1:0]       overrun,
   output logic                   timeout
);

   localparam int PCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW  = $clog2(NTASK);
   localparam int TMW = $clog2(TMO_TICKS + 1);
   localparam logic [PCW-1:0] PCNT_LAST = PCW'(TICK_DIV - 1);
   localparam logic [TMW-1:0] TMO_LAST  = TMW'(TMO_TICKS - 1);
   localparam logic [SW-1:0]  LAST_INIT = SW'(NTASK - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t           r_state;
   logic [PCW-1:0]   r_pcnt;
   logic             r_tick;
   logic [PER_W-1:0] r_cnt [NTASK];
   logic [NTASK-1:0] r_pend;
   logic [NTASK-1:0] r_ovr;
   logic [NTASK-1:0] r_grant;
   logic             r_start;
   logic             r_busy;
   logic             r_timeout;
   logic [SW-1:0]    r_last;
   logic [SW-1:0]    r_sel;
   logic [TMW-1:0]   r_tmo;

   logic [NTASK-1:0] w_active;
   logic [NTASK-1:0] w_due;
   logic [SW-1:0]    w_sel;
   logic             w_found;
   logic [NTASK-1:0] w_sel_oh;
   logic [NTASK-1:0] w_clr;
   int unsigned      v_idx;

   assign tick    = r_tick;
   assign grant   = r_grant;
   assign start   = r_start;
   assign busy    = r_busy;
   assign overrun = r_ovr;
   assign timeout = r_timeout;

   always_ff @(posedge clk50M) begin
      if (rst) begin
         r_pcnt <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= (r_pcnt == PCNT_LAST);
         r_pcnt <= (r_pcnt == PCNT_LAST) ? '0 : r_pcnt + 1'b1;
      end
   end

   always_comb begin
      w_active = '0;
      w_due    = '0;
      for (int unsigned i = 0; i < NTASK; i++) begin
         w_active[i] = en[i] && (period[i*PER_W +: PER_W] != '0);
         w_due[i]    = w_active[i] && r_tick && (r_cnt[i] == '0);
      end
   end

   always_ff @(posedge clk50M) begin
      if (rst) begin
         for (int unsigned i = 0; i < NTASK; i++) r_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NTASK; i++) begin
            if (!w_active[i])
               r_cnt[i] <= '0;
            else if (w_due[i])
               r_cnt[i] <= period[i*PER_W +: PER_W] - 1'b1;
            else if (r_tick)
               r_cnt[i] <= r_cnt[i] - 1'b1;
         end
      end
   end

   // Round-robin search starting just after the last served task.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      v_idx   = 0;
      for (int unsigned k = 1; k <= NTASK; k++) begin
         v_idx = (32'(r_last) + k) % 32'(NTASK);
         if (!w_found && r_pend[SW'(v_idx)]) begin
            w_found = 1'b1;
            w_sel   = SW'(v_idx);
         end
      end
   end

   assign w_sel_oh = {{(NTASK-1){1'b0}}, 1'b1} << w_sel;
   assign w_clr    = ((r_state == S_IDLE) && w_found) ? w_sel_oh : '0;

   // A due arriving on the grant edge keeps pend set without counting as overrun.
   always_ff @(posedge clk50M) begin
      if (rst) begin
         r_pend <= '0;
         r_ovr  <= '0;
      end else begin
         for (int unsigned i = 0; i < NTASK; i++) begin
            if (!w_active[i])
               r_pend[i] <= 1'b0;
            else if (w_due[i])
               r_pend[i] <= 1'b1;
            else if (w_clr[i])
               r_pend[i] <= 1'b0;

            if (w_due[i] && r_pend[i] && !w_clr[i])
               r_ovr[i] <= 1'b1;
            else if (flag_clr)
               r_ovr[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk50M) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_start   <= 1'b0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_last    <= LAST_INIT;
         r_sel     <= '0;
         r_tmo     <= '0;
      end else begin
         r_start <= 1'b0;
         if (flag_clr) r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= w_sel_oh;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
                  r_sel   <= w_sel;
                  r_tmo   <= '0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (done) begin
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_last  <= r_sel;
                  r_state <= S_IDLE;
               end else if (r_tick) begin
                  if (r_tmo == TMO_LAST) begin
                     r_timeout <= 1'b1;
                     r_grant   <= '0;
                     r_busy    <= 1'b0;
                     r_last    <= r_sel;
                     r_state   <= S_IDLE;
                  end else begin
                     r_tmo <= r_tmo + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_task_tick_sched.sv
// Directed bench for task_tick_sched with TICK_DIV=10 and TMO_TICKS=2;
// cycle n is the state sampled 1 time unit after the n-th edge since rst release.
module tb_task_tick_sched;

   localparam int NTASK     = 4;
   localparam int TICK_DIV  = 10;
   localparam int PER_W     = 16;
   localparam int TMO_TICKS = 2;

   logic                   clk50M = 1'b0;
   logic                   rst;
   logic [NTASK-1:0]       en;
   logic [NTASK*PER_W-1:0] period;
   logic                   done;
   logic                   flag_clr;
   logic                   tick;
   logic [NTASK-1:0]       grant;
   logic                   start;
   logic                   busy;
   logic [NTASK-1:0]       overrun;
   logic                   timeout;

   int checks = 0;
   int errors = 0;

   task_tick_sched #(
      .NTASK(NTASK), .TICK_DIV(TICK_DIV), .PER_W(PER_W), .TMO_TICKS(TMO_TICKS)
   ) dut (
      .clk50M(clk50M), .rst(rst), .en(en), .period(period), .done(done),
      .flag_clr(flag_clr), .tick(tick), .grant(grant), .start(start),
      .busy(busy), .overrun(overrun), .timeout(timeout)
   );

   always #5 clk50M = ~clk50M;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk50M);
      #1;
   endtask

   // Leaves the bench at cycle 0: rst just sampled high, now released.
   task automatic do_reset();
      rst      = 1'b1;
      en       = '0;
      period   = '0;
      done     = 1'b0;
      flag_clr = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] eg;
      logic       et, eo_t;
      logic [3:0] eo;

      rst = 1'b1; en = '0; period = '0; done = 1'b0; flag_clr = 1'b0;
      step(); step();
      chk("rst_tick", tick, 0);
      chk("rst_grant", grant, 0);
      chk("rst_start", start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout, 0);

      // Prescaler alone, nothing enabled
      do_reset();
      for (int n = 1; n <= 30; n++) begin
         step();
         chk($sformatf("t1_tick_c%0d", n), tick, (n % 10 == 0) ? 1 : 0);
         chk($sformatf("t1_start_c%0d", n), start, 0);
      end

      // Task 0 alone, period 3, done two cycles after start
      do_reset();
      en = 4'b0001;
      period[0*PER_W +: PER_W] = 16'd3;
      for (int n = 1; n <= 75; n++) begin
         step();
         eg = (n % 30 >= 12 && n % 30 <= 14) ? 4'b0001 : 4'b0000;
         chk($sformatf("t2_grant_c%0d", n), grant, eg);
         chk($sformatf("t2_start_c%0d", n), start, (n % 30 == 12) ? 1 : 0);
         chk($sformatf("t2_busy_c%0d", n), busy, (eg != 0) ? 1 : 0);
         chk($sformatf("t2_ovr_c%0d", n), overrun, 0);
         done = (n % 30 == 14);
      end
      done = 1'b0;
      chk("t2_timeout", timeout, 0);

      // All four tasks due together, done one cycle after start
      do_reset();
      en = 4'b1111;
      for (int i = 0; i < NTASK; i++) period[i*PER_W +: PER_W] = 16'd1;
      for (int n = 1; n <= 22; n++) begin
         step();
         case (n)
            12, 13:  eg = 4'b0001;
            15, 16:  eg = 4'b0010;
            18, 19:  eg = 4'b0100;
            21, 22:  eg = 4'b1000;
            default: eg = 4'b0000;
         endcase
         chk($sformatf("t3_grant_c%0d", n), grant, eg);
         chk($sformatf("t3_start_c%0d", n), start,
             (n == 12 || n == 15 || n == 18 || n == 21) ? 1 : 0);
         chk($sformatf("t3_ovr_c%0d", n), overrun, 0);
         done = (n == 13 || n == 16 || n == 19 || n == 22);
      end
      done = 1'b0;

      // last=1 with pend={0,2}: task 2 must win before task 0
      do_reset();
      en = 4'b0010;
      period[1*PER_W +: PER_W] = 16'd5;
      for (int n = 1; n <= 27; n++) begin
         step();
         if (n >= 12 && n <= 21)     eg = 4'b0010;
         else if (n == 23 || n == 24) eg = 4'b0100;
         else if (n == 26 || n == 27) eg = 4'b0001;
         else                          eg = 4'b0000;
         chk($sformatf("t3b_grant_c%0d", n), grant, eg);
         if (n == 12) begin
            en = 4'b0111;
            period[0*PER_W +: PER_W] = 16'd1;
            period[2*PER_W +: PER_W] = 16'd1;
         end
         done = (n == 21 || n == 24 || n == 27);
      end
      done = 1'b0;

      // Timeout, overrun, flag_clr (incl. set-wins), then rst mid-WAIT
      do_reset();
      en = 4'b0010;
      period[1*PER_W +: PER_W] = 16'd1;
      for (int n = 1; n <= 66; n++) begin
         step();
         if ((n >= 12 && n <= 30) || (n >= 32 && n <= 50) || n == 52 || n >= 65)
            eg = 4'b0010;
         else
            eg = 4'b0000;
         eo_t = (n == 31 || n == 32 || n == 51 || n == 52);
         eo   = eo_t ? 4'b0010 : 4'b0000;
         if (n <= 52)      et = (n % 10 == 0);
         else if (n == 53) et = 1'b0;
         else              et = ((n - 53) % 10 == 0);
         chk($sformatf("t4_grant_c%0d", n), grant, eg);
         chk($sformatf("t4_busy_c%0d", n), busy, (eg != 0) ? 1 : 0);
         chk($sformatf("t4_timeout_c%0d", n), timeout, eo_t);
         chk($sformatf("t4_ovr_c%0d", n), overrun, eo);
         chk($sformatf("t4_tick_c%0d", n), tick, et);
         chk($sformatf("t4_start_c%0d", n), start,
             (n == 12 || n == 32 || n == 52 || n == 65) ? 1 : 0);
         flag_clr = (n == 32 || n == 50);
         rst      = (n == 52);
      end
      flag_clr = 1'b0;

      // Disable while pending (never granted), disable while granted (held)
      do_reset();
      en = 4'b0101;
      period[0*PER_W +: PER_W] = 16'd1;
      period[2*PER_W +: PER_W] = 16'd1;
      for (int n = 1; n <= 38; n++) begin
         step();
         if (n == 12 || n == 13 || n == 22 || n == 23 || n == 37 || n == 38)
            eg = 4'b0001;
         else if (n >= 32 && n <= 35)
            eg = 4'b0100;
         else
            eg = 4'b0000;
         chk($sformatf("t6_grant_c%0d", n), grant, eg);
         chk($sformatf("t6_busy_c%0d", n), busy, (eg != 0) ? 1 : 0);
         if (n == 12 || n == 32) en = 4'b0001;
         if (n == 25)            en = 4'b0101;
         done = (n == 13 || n == 23 || n == 35 || n == 38);
      end
      done = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
